// File: rtl/issue_dispatch_ctrl_pkg.sv
// Shared types for the issue stage: buffer geometry, unit classes, entry
// state, and the payload records held by the dispatch port registers.
package issue_dispatch_ctrl_pkg;

    localparam int unsigned BUF_SIZE     = 8;
    localparam int unsigned BUF_SIZE_LOG = $clog2(BUF_SIZE);

    typedef logic [BUF_SIZE_LOG-1:0] idx_t;
    typedef logic [BUF_SIZE_LOG:0]   tag_t;

    typedef enum logic [1:0] {
        UNIT_ALU    = 2'd0,
        UNIT_BRANCH = 2'd1,
        UNIT_LOAD   = 2'd2,
        UNIT_STORE  = 2'd3
    } unit_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAITING   = 2'd1,
        S_EXECUTING = 2'd2,
        S_DONE      = 2'd3
    } e_state_t;

    typedef struct packed {
        e_state_t state;
        tag_t     tag;
        unit_t    unit;
    } entry_t;

    // Port A never carries memory ops, so its payload has no unit field.
    typedef struct packed {
        idx_t idx;
        tag_t tag;
    } pa_payload_t;

    typedef struct packed {
        idx_t  idx;
        tag_t  tag;
        unit_t unit;
    } pb_payload_t;

    function automatic logic is_mem(input unit_t u);
        return (u == UNIT_LOAD) || (u == UNIT_STORE);
    endfunction

endpackage

// File: rtl/issue_dispatch_ctrl_port_reg.sv
// One valid/ready holding register for an execution port.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   flush        drops the held op at the next edge
//   load_en      capture load_data (only asserted when the port is free)
//   load_data    payload to capture
//   out_ready    consumer takes the held op this cycle
//   out_valid    register holds an op
//   out_data     held payload, stable while out_valid & !out_ready
//   free         register can accept a new op this cycle
module issue_dispatch_ctrl_port_reg #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic load_en,
    input  T     load_data,
    input  logic out_ready,
    output logic out_valid,
    output T     out_data,
    output logic free
);

    logic valid_q, valid_d;
    T     data_q,  data_d;

    assign free      = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_en) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/issue_dispatch_ctrl.sv
// Issue-stage dispatch: binds up to two ready candidates per cycle to port A
// (ALU/BRANCH) and port B (LOAD/STORE/ALU), reports accepted entries back to
// the buffer, and caps outstanding memory ops at MEM_MAX.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      squash held ports, suppress acceptance
//   cand_valid/idx/tag/unit    two candidates, slot 0 has priority
//   pa_valid/idx/tag, pa_ready port A valid/ready output
//   pb_valid/idx/tag/unit, pb_ready  port B valid/ready output
//   mem_done                   one memory op completed
//   issued_valid/issued_idx    combinational accept report per candidate
//   mem_inflight               outstanding memory op count
//   err_underflow              sticky: mem_done seen with count at zero
module issue_dispatch_ctrl
    import issue_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned MEM_MAX = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [1:0]                        cand_valid,
    input  logic [1:0][BUF_SIZE_LOG-1:0]      cand_idx,
    input  logic [1:0][BUF_SIZE_LOG:0]        cand_tag,
    input  unit_t [1:0]                       cand_unit,
    output logic                              pa_valid,
    output logic [BUF_SIZE_LOG-1:0]           pa_idx,
    output logic [BUF_SIZE_LOG:0]             pa_tag,
    input  logic                              pa_ready,
    output logic                              pb_valid,
    output logic [BUF_SIZE_LOG-1:0]           pb_idx,
    output logic [BUF_SIZE_LOG:0]             pb_tag,
    output unit_t                             pb_unit,
    input  logic                              pb_ready,
    input  logic                              mem_done,
    output logic [1:0]                        issued_valid,
    output logic [1:0][BUF_SIZE_LOG-1:0]      issued_idx,
    output logic [$clog2(MEM_MAX+1)-1:0]      mem_inflight,
    output logic                              err_underflow
);

    localparam int unsigned CNT_W = $clog2(MEM_MAX + 1);
    localparam logic [CNT_W:0] MEM_LIMIT = (CNT_W + 1)'(MEM_MAX);

    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic             err_q, err_d;

    logic        pa_free, pb_free;
    logic        pa_load, pb_load;
    pa_payload_t pa_load_data, pa_data;
    pb_payload_t pb_load_data, pb_data;

    logic        c0_a, c0_b, c1_a, c1_b;
    logic        c0_mem, c1_mem, en0, en1, a1_free, b1_free;
    logic        pb_mem_held, mem_issue, mem_ok;
    logic [CNT_W:0] mem_sum;

    // An op held on B with a mem unit is already committed to the LSU, so it
    // counts against the cap even before its handshake.
    assign pb_mem_held = pb_valid && is_mem(pb_data.unit);
    assign mem_sum     = {1'b0, mem_cnt_q} + {{CNT_W{1'b0}}, pb_mem_held};
    assign mem_ok      = mem_sum < MEM_LIMIT;
    assign mem_issue   = pb_mem_held && pb_ready;

    always_comb begin
        c0_a    = 1'b0;
        c0_b    = 1'b0;
        c1_a    = 1'b0;
        c1_b    = 1'b0;
        c0_mem  = is_mem(cand_unit[0]);
        c1_mem  = is_mem(cand_unit[1]);
        en0     = rst_n && !flush && cand_valid[0];
        if (en0) begin
            if (c0_mem) begin
                c0_b = pb_free && mem_ok;
            end else if (pa_free) begin
                c0_a = 1'b1;
            end else if (cand_unit[0] == UNIT_ALU) begin
                c0_b = pb_free;
            end
        end
        a1_free = pa_free && !c0_a;
        b1_free = pb_free && !c0_b;
        en1     = rst_n && !flush && cand_valid[1]
                  && !(cand_valid[0] && (cand_idx[1] == cand_idx[0]))
                  && !(c1_mem && c0_b && c0_mem);
        if (en1) begin
            if (c1_mem) begin
                c1_b = b1_free && mem_ok;
            end else if (a1_free) begin
                c1_a = 1'b1;
            end else if (cand_unit[1] == UNIT_ALU) begin
                c1_b = b1_free;
            end
        end
    end

    assign issued_valid = {c1_a || c1_b, c0_a || c0_b};
    assign issued_idx   = cand_idx;

    assign pa_load      = c0_a || c1_a;
    assign pb_load      = c0_b || c1_b;
    assign pa_load_data = c0_a ? pa_payload_t'{cand_idx[0], cand_tag[0]}
                               : pa_payload_t'{cand_idx[1], cand_tag[1]};
    assign pb_load_data = c0_b ? pb_payload_t'{cand_idx[0], cand_tag[0], cand_unit[0]}
                               : pb_payload_t'{cand_idx[1], cand_tag[1], cand_unit[1]};

    issue_dispatch_ctrl_port_reg #(.T(pa_payload_t)) u_port_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load_en   (pa_load),
        .load_data (pa_load_data),
        .out_ready (pa_ready),
        .out_valid (pa_valid),
        .out_data  (pa_data),
        .free      (pa_free)
    );

    issue_dispatch_ctrl_port_reg #(.T(pb_payload_t)) u_port_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load_en   (pb_load),
        .load_data (pb_load_data),
        .out_ready (pb_ready),
        .out_valid (pb_valid),
        .out_data  (pb_data),
        .free      (pb_free)
    );

    assign pa_idx  = pa_data.idx;
    assign pa_tag  = pa_data.tag;
    assign pb_idx  = pb_data.idx;
    assign pb_tag  = pb_data.tag;
    assign pb_unit = pb_data.unit;

    // A handshake during flush still counts: the LSU took the op.
    always_comb begin
        mem_cnt_d = mem_cnt_q;
        err_d     = err_q;
        if (mem_issue && !mem_done) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end else if (!mem_issue && mem_done) begin
            if (mem_cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                mem_cnt_d = mem_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            err_q     <= err_d;
        end
    end

    assign mem_inflight  = mem_cnt_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
module tb_issue_dispatch_ctrl;
    import issue_dispatch_ctrl_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [1:0]        cand_valid;
    logic [1:0][2:0]   cand_idx;
    logic [1:0][3:0]   cand_tag;
    unit_t [1:0]       cand_unit;
    logic              pa_valid, pa_ready;
    logic [2:0]        pa_idx;
    logic [3:0]        pa_tag;
    logic              pb_valid, pb_ready;
    logic [2:0]        pb_idx;
    logic [3:0]        pb_tag;
    unit_t             pb_unit;
    logic              mem_done;
    logic [1:0]        issued_valid;
    logic [1:0][2:0]   issued_idx;
    logic [1:0]        mem_inflight;
    logic              err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]      v;
        logic [1:0][2:0] idx;
    } iss_exp_t;

    iss_exp_t    iss_q[$];
    pa_payload_t qa[$];
    pb_payload_t qb[$];

    issue_dispatch_ctrl #(.MEM_MAX(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .cand_valid    (cand_valid),
        .cand_idx      (cand_idx),
        .cand_tag      (cand_tag),
        .cand_unit     (cand_unit),
        .pa_valid      (pa_valid),
        .pa_idx        (pa_idx),
        .pa_tag        (pa_tag),
        .pa_ready      (pa_ready),
        .pb_valid      (pb_valid),
        .pb_idx        (pb_idx),
        .pb_tag        (pb_tag),
        .pb_unit       (pb_unit),
        .pb_ready      (pb_ready),
        .mem_done      (mem_done),
        .issued_valid  (issued_valid),
        .issued_idx    (issued_idx),
        .mem_inflight  (mem_inflight),
        .err_underflow (err_underflow)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] tg(input int idx);
        return 4'(idx + 9);
    endfunction

    task automatic clear_in();
        flush      = 1'b0;
        cand_valid = '0;
        cand_idx   = '0;
        cand_tag   = '0;
        cand_unit  = {UNIT_ALU, UNIT_ALU};
        pa_ready   = 1'b0;
        pb_ready   = 1'b0;
        mem_done   = 1'b0;
    endtask

    task automatic set_cand(input int k, input int idx, input unit_t u);
        cand_valid[k] = 1'b1;
        cand_idx[k]   = 3'(idx);
        cand_tag[k]   = tg(idx);
        cand_unit[k]  = u;
    endtask

    task automatic push_a(input int idx);
        qa.push_back(pa_payload_t'{3'(idx), tg(idx)});
    endtask

    task automatic push_b(input int idx, input unit_t u);
        qb.push_back(pb_payload_t'{3'(idx), tg(idx), u});
    endtask

    // Records the expected accept report for the cycle just driven, then
    // advances to 1 time unit after the next rising edge.
    task automatic step(input logic [1:0] ev);
        iss_exp_t e;
        e.v   = ev;
        e.idx = cand_idx;
        iss_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the accept report every cycle and each port payload
    // at its handshake.
    always @(negedge clk) begin
        iss_exp_t    e;
        pa_payload_t ea;
        pb_payload_t eb;
        if (iss_q.size() > 0) begin
            e = iss_q.pop_front();
            chk("issued_valid", 32'(issued_valid), 32'(e.v));
            for (int k = 0; k < 2; k++)
                if (e.v[k]) chk("issued_idx", 32'(issued_idx[k]), 32'(e.idx[k]));
        end
        if (rst_n && pa_valid && pa_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pa_unexpected: handshake idx %0d, none expected", pa_idx);
            end else begin
                ea = qa.pop_front();
                chk("pa_idx", 32'(pa_idx), 32'(ea.idx));
                chk("pa_tag", 32'(pa_tag), 32'(ea.tag));
            end
        end
        if (rst_n && pb_valid && pb_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pb_unexpected: handshake idx %0d, none expected", pb_idx);
            end else begin
                eb = qb.pop_front();
                chk("pb_idx", 32'(pb_idx), 32'(eb.idx));
                chk("pb_tag", 32'(pb_tag), 32'(eb.tag));
                chk("pb_unit", 32'(pb_unit), 32'(eb.unit));
            end
        end
    end

    initial begin
        clear_in();
        rst_n = 1'b0;
        // Reset: candidates present but nothing accepted.
        set_cand(0, 3, UNIT_ALU);
        step(2'b00);
        chk("rst_pa_valid", 32'(pa_valid), 0);
        chk("rst_pb_valid", 32'(pb_valid), 0);
        chk("rst_inflight", 32'(mem_inflight), 0);
        chk("rst_err", 32'(err_underflow), 0);
        clear_in();
        rst_n = 1'b1;
        step(2'b00);

        // Dual dispatch ALU->A, LOAD->B.
        set_cand(0, 3, UNIT_ALU); set_cand(1, 5, UNIT_LOAD);
        push_a(3); push_b(5, UNIT_LOAD);
        step(2'b11);
        chk("t2_pa_idx", 32'(pa_idx), 3);
        chk("t2_pb_idx", 32'(pb_idx), 5);
        clear_in(); pa_ready = 1'b1; pb_ready = 1'b1;
        step(2'b00);
        chk("t2_inflight", 32'(mem_inflight), 1);
        clear_in(); mem_done = 1'b1;
        step(2'b00);
        chk("t2_inflight_done", 32'(mem_inflight), 0);

        // A busy: ALU overflows to B, cand1 has nowhere to go.
        clear_in(); set_cand(0, 6, UNIT_ALU); push_a(6);
        step(2'b01);
        clear_in(); set_cand(0, 1, UNIT_ALU); set_cand(1, 2, UNIT_ALU); push_b(1, UNIT_ALU);
        step(2'b01);
        chk("t3_pa_hold", 32'({pa_valid, pa_idx}), 32'({1'b1, 3'd6}));
        chk("t3_pb_idx", 32'(pb_idx), 1);
        clear_in(); pa_ready = 1'b1; pb_ready = 1'b1;
        step(2'b00);
        chk("t3_inflight", 32'(mem_inflight), 0);

        // Memory cap with a held STORE; simultaneous handshake and mem_done.
        clear_in(); set_cand(0, 4, UNIT_STORE); push_b(4, UNIT_STORE);
        step(2'b01);
        clear_in(); pb_ready = 1'b1;
        step(2'b00);
        clear_in(); set_cand(0, 7, UNIT_STORE); push_b(7, UNIT_STORE);
        step(2'b01);
        clear_in(); set_cand(0, 2, UNIT_LOAD);
        step(2'b00);
        chk("t4_inflight1", 32'(mem_inflight), 1);
        pb_ready = 1'b1; mem_done = 1'b1;
        step(2'b00);
        chk("t4_inflight_same", 32'(mem_inflight), 1);
        pb_ready = 1'b0; mem_done = 1'b0; push_b(2, UNIT_LOAD);
        step(2'b01);
        chk("t4_pb_load", 32'({pb_valid, pb_idx}), 32'({1'b1, 3'd2}));
        clear_in(); pb_ready = 1'b1;
        step(2'b00);
        chk("t4_inflight2", 32'(mem_inflight), 2);
        clear_in(); mem_done = 1'b1;
        step(2'b00);
        step(2'b00);
        chk("t4_inflight0", 32'(mem_inflight), 0);

        // One mem dispatch per cycle; equal index drop; BRANCH never to B.
        clear_in(); set_cand(0, 1, UNIT_LOAD); set_cand(1, 3, UNIT_STORE); push_b(1, UNIT_LOAD);
        step(2'b01);
        clear_in(); pb_ready = 1'b1;
        step(2'b00);
        clear_in(); mem_done = 1'b1;
        step(2'b00);
        clear_in(); set_cand(0, 5, UNIT_ALU); set_cand(1, 5, UNIT_ALU); push_a(5);
        step(2'b01);
        chk("t5_pb_empty", 32'(pb_valid), 0);
        clear_in(); pa_ready = 1'b1;
        step(2'b00);
        clear_in(); set_cand(0, 0, UNIT_ALU); push_a(0);
        step(2'b01);
        clear_in(); set_cand(0, 2, UNIT_BRANCH); set_cand(1, 3, UNIT_ALU); push_b(3, UNIT_ALU);
        step(2'b10);
        clear_in(); pa_ready = 1'b1; pb_ready = 1'b1;
        step(2'b00);
        chk("t5_inflight", 32'(mem_inflight), 0);

        // Flush with a mem handshake, then underflow.
        clear_in(); set_cand(0, 1, UNIT_ALU); set_cand(1, 2, UNIT_LOAD);
        push_a(1); push_b(2, UNIT_LOAD);
        step(2'b11);
        clear_in(); flush = 1'b1; pb_ready = 1'b1; set_cand(0, 4, UNIT_ALU);
        qa.delete();
        step(2'b00);
        chk("t6_ports_empty", 32'({pa_valid, pb_valid}), 0);
        chk("t6_inflight", 32'(mem_inflight), 1);
        clear_in(); mem_done = 1'b1;
        step(2'b00);
        chk("t6_err_pre", 32'(err_underflow), 0);
        step(2'b00);
        chk("t6_err_set", 32'({err_underflow, mem_inflight}), 32'({1'b1, 2'd0}));
        clear_in();
        step(2'b00);
        chk("t6_err_sticky", 32'(err_underflow), 1);

        // Mid-run asynchronous reset with A held and two mem ops outstanding.
        clear_in(); set_cand(0, 3, UNIT_ALU); set_cand(1, 1, UNIT_LOAD);
        push_a(3); push_b(1, UNIT_LOAD);
        step(2'b11);
        clear_in(); pb_ready = 1'b1; set_cand(0, 2, UNIT_STORE); push_b(2, UNIT_STORE);
        step(2'b01);
        clear_in(); pb_ready = 1'b1;
        step(2'b00);
        chk("t1_pre", 32'({pa_valid, mem_inflight}), 32'({1'b1, 2'd2}));
        clear_in(); set_cand(0, 4, UNIT_ALU);
        #2;
        rst_n = 1'b0;
        qa.delete(); qb.delete();
        #1;
        chk("t1_valids", 32'({pa_valid, pb_valid}), 0);
        chk("t1_payload", 32'({pa_idx, pa_tag, pb_idx, pb_tag, pb_unit}), 0);
        chk("t1_inflight", 32'(mem_inflight), 0);
        chk("t1_err", 32'(err_underflow), 0);
        chk("t1_issued", 32'(issued_valid), 0);
        step(2'b00);
        rst_n = 1'b1;
        clear_in(); set_cand(0, 7, UNIT_ALU); push_a(7);
        step(2'b01);
        clear_in(); pa_ready = 1'b1;
        step(2'b00);
        clear_in();
        step(2'b00);

        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
